// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants and the 2-bit to 12-bit code expansion for the capture register bank.
package reg_bank_arbiter_pkg;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned CODE_W    = 2;
    localparam int unsigned N_DEFAULT = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    // Bank replication pattern: b1 fills 11..4 and bit 2, b0 fills bit 3 and 1..0.
    function automatic logic [DATA_W-1:0] expand(input logic [CODE_W-1:0] code);
        return {{8{code[1]}}, code[0], code[1], {2{code[0]}}};
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo N.
module rr_pick
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned N   = N_DEFAULT,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [IDW-1:0] k;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDW'((32'(ptr_i) + i) % N);
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin load sequencer: grants one requester per load into a registered valid/ready stage.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned N   = N_DEFAULT,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic                 i1,
    input  logic                 i2,
    input  logic [N-1:0]         i3,
    input  logic [CODE_W*N-1:0]  i4,
    input  logic                 i5,
    output logic [N-1:0]         o1,
    output logic [DATA_W-1:0]    o2,
    output logic                 o3,
    output logic [IDW-1:0]       o4
);

    stage_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [IDW-1:0]      idx_q,   idx_d;
    logic [IDW-1:0]      ptr_q,   ptr_d;

    logic [N-1:0]        win_onehot;
    logic [IDW-1:0]      win_idx;
    logic                win_any;
    logic [CODE_W-1:0]   win_code;
    logic                load_en;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i   (i3),
        .ptr_i   (ptr_q),
        .grant_o (win_onehot),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // Accept when empty, or when full and drained on the same edge.
    assign load_en = win_any & ((state_q == EMPTY) | i5);
    assign o1      = (load_en && !i2) ? win_onehot : '0;

    // Code selected by one-hot so the mux stays constant-indexed.
    always_comb begin
        win_code = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (win_onehot[k]) begin
                win_code = i4[k*CODE_W +: CODE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            state_d = FULL;
            data_d  = expand(win_code);
            idx_d   = win_idx;
            ptr_d   = (win_idx == IDW'(N-1)) ? '0 : win_idx + IDW'(1);
        end else if (state_q == FULL && i5) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i1 or posedge i2) begin
        if (i2) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o2 = data_q;
    assign o3 = (state_q == FULL);
    assign o4 = idx_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed-vector bench for reg_bank_arbiter with N=4 and hand-computed expectations.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  codes;
    logic        rdy;
    logic [3:0]  gnt;
    logic [11:0] data;
    logic        valid;
    logic [1:0]  idx;

    int vectors;
    int miscompares;

    logic [11:0] exp_data [4];

    reg_bank_arbiter #(
        .N   (4),
        .IDW (2)
    ) dut (
        .i1 (clk),
        .i2 (rst),
        .i3 (req),
        .i4 (codes),
        .i5 (rdy),
        .o1 (gnt),
        .o2 (data),
        .o3 (valid),
        .o4 (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; codes = '0; rdy = 1'b0;
        step(); step();
        vectors++; if (data !== 12'h000) begin miscompares++; $display("FAIL reset_o2 got %h want 000", data); end
        vectors++; if (valid !== 1'b0)   begin miscompares++; $display("FAIL reset_o3 got %b want 0", valid); end
        vectors++; if (idx !== 2'd0)     begin miscompares++; $display("FAIL reset_o4 got %0d want 0", idx); end
        vectors++; if (gnt !== 4'b0000)  begin miscompares++; $display("FAIL reset_o1 got %b want 0000", gnt); end
        rst = 1'b0;
        req = 4'b0001; codes = 8'b00_00_00_11;
        #1;
        vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL pre_fill_o1 got %b want 0001", gnt); end
        step();
        req = 4'b1111; rdy = 1'b1;
        vectors++; if (valid !== 1'b1 || data !== 12'hFFF) begin miscompares++; $display("FAIL fill got v=%b d=%h want v=1 d=FFF", valid, data); end
        // Mid-cycle reset while full.
        #2 rst = 1'b1;
        #1;
        vectors++; if (data !== 12'h000) begin miscompares++; $display("FAIL midrst_o2 got %h want 000", data); end
        vectors++; if (valid !== 1'b0)   begin miscompares++; $display("FAIL midrst_o3 got %b want 0", valid); end
        vectors++; if (idx !== 2'd0)     begin miscompares++; $display("FAIL midrst_o4 got %0d want 0", idx); end
        vectors++; if (gnt !== 4'b0000)  begin miscompares++; $display("FAIL midrst_o1 got %b want 0000", gnt); end
        step();
        rst = 1'b0;
        req = 4'b1010; codes = 8'b11_10_01_00; rdy = 1'b1;
        #1;
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL first_grant got %b want 0010", gnt); end
        step();
        vectors++; if (idx !== 2'd1 || data !== 12'h00B || valid !== 1'b1) begin
            miscompares++; $display("FAIL first_load got i=%0d d=%h v=%b want i=1 d=00B v=1", idx, data, valid);
        end
    endtask

    task automatic test_expansion();
        req = 4'b0000; rdy = 1'b1;
        step();
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL exp_predrain got %b want 0", valid); end
        for (int c = 0; c < 4; c++) begin
            req = 4'b0001; codes = {6'b0, 2'(c)};
            #1;
            vectors++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL exp_grant%0d got %b want 0001", c, gnt); end
            step();
            vectors++; if (data !== exp_data[c] || idx !== 2'd0 || valid !== 1'b1) begin
                miscompares++; $display("FAIL exp_code%0d got d=%h i=%0d v=%b want d=%h i=0 v=1", c, data, idx, valid, exp_data[c]);
            end
        end
    endtask

    task automatic test_fairness();
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; codes = 8'b11_10_01_00; rdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            logic [1:0] w;
            logic [3:0] oh;
            w  = 2'(n % 4);
            oh = 4'b0001 << w;
            #1;
            vectors++; if (gnt !== oh) begin miscompares++; $display("FAIL rr_grant%0d got %b want %b", n, gnt, oh); end
            step();
            vectors++; if (idx !== w || valid !== 1'b1 || data !== exp_data[w]) begin
                miscompares++; $display("FAIL rr_load%0d got i=%0d v=%b d=%h want i=%0d v=1 d=%h", n, idx, valid, data, w, exp_data[w]);
            end
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0100; rdy = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL bp_grant%0d got %b want 0000", n, gnt); end
            step();
            vectors++; if (data !== 12'h00B || idx !== 2'd1 || valid !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold%0d got d=%h i=%0d v=%b want d=00B i=1 v=1", n, data, idx, valid);
            end
        end
        rdy = 1'b1;
        #1;
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL bp_release got %b want 0100", gnt); end
        step();
        vectors++; if (data !== 12'hFF4 || idx !== 2'd2 || valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_reload got d=%h i=%0d v=%b want d=FF4 i=2 v=1", data, idx, valid);
        end
    endtask

    task automatic test_drain();
        req = 4'b0000; rdy = 1'b1;
        #1;
        vectors++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL drain_grant got %b want 0000", gnt); end
        step();
        vectors++; if (valid !== 1'b0 || data !== 12'hFF4 || idx !== 2'd2) begin
            miscompares++; $display("FAIL drain got v=%b d=%h i=%0d want v=0 d=FF4 i=2", valid, data, idx);
        end
    endtask

    task automatic test_skip();
        // Pointer sits at 3 after the back-pressure reload of requester 2.
        req = 4'b0110; rdy = 1'b1;
        #1;
        vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL skip_grant1 got %b want 0010", gnt); end
        step();
        vectors++; if (idx !== 2'd1 || data !== 12'h00B) begin miscompares++; $display("FAIL skip_load1 got i=%0d d=%h want i=1 d=00B", idx, data); end
        #1;
        vectors++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL skip_grant2 got %b want 0100", gnt); end
        step();
        vectors++; if (idx !== 2'd2 || data !== 12'hFF4) begin miscompares++; $display("FAIL skip_load2 got i=%0d d=%h want i=2 d=FF4", idx, data); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_data[0] = 12'h000;
        exp_data[1] = 12'h00B;
        exp_data[2] = 12'hFF4;
        exp_data[3] = 12'hFFF;
        test_reset();
        test_expansion();
        test_fairness();
        test_backpressure();
        test_drain();
        test_skip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
